line_burst_adapter: RTL and testbench

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/cache_pkg.sv | 17 +
 rtl/burst_watchdog.sv | 31 +++
 rtl/line_burst_adapter.sv | 151 +++++++++++++++
 tb/tb_line_burst_adapter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side definitions: default line geometry, adapter state type and
// the packed line vector type.
package cache_pkg;

   localparam int unsigned LINE_WORDS_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_BURST,
      RESP,
      RELEASE
   } state_t;

   typedef logic [32*LINE_WORDS_DEFAULT-1:0] line_t;

endpackage

// File: rtl/burst_watchdog.sv
// Beat watchdog: flags a strobe that has gone TMO_CYCLES cycles without mm_ack.
// Only instantiated when BURST_TIMEOUT_EN is defined.
module burst_watchdog #(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic mm_ack,
   output logic timeout
);

   localparam int unsigned CW = $clog2(TMO_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Count consecutive unacknowledged strobe cycles; any ack or idle cycle restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (strobe && !mm_ack) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end

   // Fires during the TMO_CYCLES-th unacknowledged cycle so the burst aborts at its end.
   assign timeout = strobe && !mm_ack && (cnt_q == CW'(TMO_CYCLES - 1));

endmodule

// File: rtl/line_burst_adapter.sv
// Cache-line to single-word main-memory burst adapter.
// Optional beat watchdog enabled by defining BURST_TIMEOUT_EN.
module line_burst_adapter
   import cache_pkg::*;
#(
   parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [31:0]             line_addr,
   input  logic [32*LINE_WORDS-1:0] wb_line,
   output logic [32*LINE_WORDS-1:0] fill_line,
   output logic                    ca_resp,
   output logic [31:0]             mm_addr,
   output logic [31:0]             mm_wdata,
   input  logic [31:0]             mm_rdata,
   output logic                    mm_rd,
   output logic                    mm_wr,
   input  logic                    mm_ack,
   output logic                    error
);

   localparam int unsigned BW = $clog2(LINE_WORDS);
   localparam int unsigned LW = 32 * LINE_WORDS;

   state_t          state_q, state_d;
   logic [29-BW:0]  base_q;
   logic [BW-1:0]   beat_q;
   logic [LW-1:0]   wb_q;
   logic [LW-1:0]   fill_q;
   logic            served_wr_q;
   logic            err_q;
   logic            accept;
   logic            strobe;
   logic            last_beat;
   logic            abort;
   logic [BW+4:0]   word_lsb;

   assign strobe    = (state_q == WR_BURST) || (state_q == RD_BURST);
   assign last_beat = (beat_q == BW'(LINE_WORDS - 1));
   assign word_lsb  = {beat_q, 5'd0};

   // Outputs are decoded from state so an async reset clears them in the same cycle.
   assign mm_addr   = strobe ? {base_q, beat_q, 2'b00} : '0;
   assign mm_wdata  = mm_wr ? wb_q[word_lsb +: 32] : '0;
   assign fill_line = fill_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode; write wins when both requests are pending.
   always_comb begin
      state_d = state_q;
      mm_rd   = 1'b0;
      mm_wr   = 1'b0;
      ca_resp = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_write || mem_read) begin
               accept  = 1'b1;
               state_d = mem_write ? WR_BURST : RD_BURST;
            end
         end
         WR_BURST, RD_BURST: begin
            mm_wr = (state_q == WR_BURST);
            mm_rd = (state_q == RD_BURST);
            if (abort || (mm_ack && last_beat)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            ca_resp = 1'b1;
            state_d = RELEASE;
         end
         RELEASE: begin
            // Only the request that was served is watched here.
            if (served_wr_q ? !mem_write : !mem_read) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, beat counter (wraps modulo LINE_WORDS) and abort flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q      <= '0;
         beat_q      <= '0;
         wb_q        <= '0;
         served_wr_q <= 1'b0;
         err_q       <= 1'b0;
      end else if (accept) begin
         base_q      <= line_addr[31:BW+2];
         beat_q      <= '0;
         wb_q        <= wb_line;
         served_wr_q <= mem_write;
         err_q       <= 1'b0;
      end else if (strobe) begin
         if (mm_ack) begin
            beat_q <= beat_q + 1'b1;
         end
         if (abort) begin
            err_q <= 1'b1;
         end
      end
   end

   // Fill buffer: one word captured per acknowledged read beat, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q <= '0;
      end else if (mm_rd && mm_ack) begin
         fill_q[word_lsb +: 32] <= mm_rdata;
      end
   end

`ifdef BURST_TIMEOUT_EN
   burst_watchdog #(
      .TMO_CYCLES(TMO_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .strobe  (strobe),
      .mm_ack  (mm_ack),
      .timeout (abort)
   );

   assign error = err_q && (state_q == RESP);
`else
   logic unused_cfg;

   assign abort      = 1'b0;
   assign error      = 1'b0;
   assign unused_cfg = ^{TMO_CYCLES, err_q};
`endif

   logic unused_addr;
   assign unused_addr = ^line_addr[BW+1:0];

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: stimulus pushes expected beats and
// responses, a monitor pops and compares them as the DUT produces them.
module tb_line_burst_adapter;
   import cache_pkg::*;

   localparam int unsigned LW_N = LINE_WORDS_DEFAULT;
   localparam int unsigned TMO  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] line_addr;
   line_t       wb_line, fill_line;
   logic        ca_resp, mm_rd, mm_wr, mm_ack, error;
   logic [31:0] mm_addr, mm_wdata, mm_rdata;

   always #5 clk = ~clk;

   line_burst_adapter #(
      .LINE_WORDS (LW_N),
      .TMO_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .line_addr (line_addr),
      .wb_line   (wb_line),
      .fill_line (fill_line),
      .ca_resp   (ca_resp),
      .mm_addr   (mm_addr),
      .mm_wdata  (mm_wdata),
      .mm_rdata  (mm_rdata),
      .mm_rd     (mm_rd),
      .mm_wr     (mm_wr),
      .mm_ack    (mm_ack),
      .error     (error)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
   } beat_t;

   typedef struct {
      line_t fill;
      logic  err;
   } resp_t;

   beat_t       exp_beats[$];
   resp_t       exp_resp[$];
   int          total = 0;
   int          bad = 0;
   int          resp_seen = 0;
   int          resp_pushed = 0;
   int          err_seen = 0;
   int          err_pushed = 0;
   int          wait_n = 0;
   bit          no_ack = 0;
   logic [31:0] mem [0:255];
   line_t       model_fill;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // Reference model: a line request becomes LW_N ascending word beats and one response.
   task automatic push_req(input bit wr, input logic [31:0] addr, input line_t wb, input int wn);
      logic [31:0] base;
      line_t       f;
      resp_t       r;
      base = addr & ~32'(LW_N * 4 - 1);
      f    = model_fill;
      for (int i = 0; i < int'(LW_N); i++) begin
         beat_t b;
         b.wr    = wr;
         b.addr  = base + 32'(4 * i);
         b.wdata = wr ? wb[32*i +: 32] : 32'd0;
         b.hold  = wn + 1;
         exp_beats.push_back(b);
         if (!wr) f[32*i +: 32] = mem[((base >> 2) + 32'(i)) & 32'hFF];
      end
      model_fill = f;
      r.fill = f;
      r.err  = 1'b0;
      exp_resp.push_back(r);
      resp_pushed++;
   endtask

   // Returns the number of cycles from the request until ca_resp (cycle 1 is the
   // first cycle spent in the burst state).
   task automatic wait_resp(output int n);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         step();
         n++;
         if (ca_resp) return;
      end
      chk("resp_timeout", 0, 1);
   endtask

   task automatic drop_and_settle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      step();
   endtask

   // Memory responder: acks each beat after wait_n wait cycles.
   initial begin
      int w;
      w = 0;
      mm_ack   = 1'b0;
      mm_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            w      = 0;
            mm_ack = 1'b0;
         end else if ((mm_rd || mm_wr) && !no_ack) begin
            if (w >= wait_n) begin
               mm_ack   = 1'b1;
               mm_rdata = mem[mm_addr[9:2]];
               w        = 0;
            end else begin
               mm_ack   = 1'b0;
               mm_rdata = $urandom;
               w++;
            end
         end else begin
            mm_ack   = 1'b0;
            mm_rdata = $urandom;
            w        = 0;
         end
      end
   end

   // Monitor: compares every acknowledged beat and every ca_resp with the queues.
   initial begin
      int          hold;
      logic [31:0] prev_addr, prev_wdata;
      logic        prev_wr;
      hold = 0;
      prev_addr = '0;
      prev_wdata = '0;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            hold = 0;
         end else begin
            if (mm_rd || mm_wr) begin
               chk("strobe_excl", mm_rd & mm_wr, 0);
               if (hold > 0) begin
                  chk("hold_addr", mm_addr, prev_addr);
                  chk("hold_wdata", mm_wdata, prev_wdata);
                  chk("hold_dir", mm_wr, prev_wr);
               end
               hold++;
               if (mm_ack) begin
                  if (exp_beats.size() == 0) begin
                     chk("unexpected_beat", mm_addr, 32'hFFFF_FFFF);
                  end else begin
                     beat_t b;
                     b = exp_beats.pop_front();
                     chk("beat_dir", mm_wr, b.wr);
                     chk("beat_addr", mm_addr, b.addr);
                     if (b.wr) chk("beat_wdata", mm_wdata, b.wdata);
                     chk("beat_hold", hold, b.hold);
                  end
                  hold = 0;
               end
               prev_addr  = mm_addr;
               prev_wdata = mm_wdata;
               prev_wr    = mm_wr;
            end else begin
               hold = 0;
            end
            if (ca_resp) begin
               resp_seen++;
               if (exp_resp.size() == 0) begin
                  chk("unexpected_resp", 1, 0);
               end else begin
                  resp_t r;
                  r = exp_resp.pop_front();
                  chk("resp_fill", fill_line, r.fill);
                  chk("resp_error", error, r.err);
               end
            end
            if (error) err_seen++;
         end
      end
   end

   initial begin
      int    n;
      int    r0;
      bit    found;
      line_t wb;
      logic [31:0] a;

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[8'h8C + i] = 32'hA0 + 32'(i);
      model_fill = '0;
      rst = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      line_addr = '0;
      wb_line = '0;
      repeat (3) step();

      // Reset state.
      chk("rst_mm_rd", mm_rd, 0);
      chk("rst_mm_wr", mm_wr, 0);
      chk("rst_ca_resp", ca_resp, 0);
      chk("rst_error", error, 0);
      chk("rst_fill", fill_line, 0);
      chk("rst_mm_addr", mm_addr, 0);
      chk("rst_mm_wdata", mm_wdata, 0);
      rst = 1'b0;
      step();

      // Zero-wait fill of line 0x1230.
      wait_n = 0;
      push_req(1'b0, 32'h1234, '0, 0);
      line_addr = 32'h1234;
      mem_read = 1'b1;
      wait_resp(n);
      chk("fill_latency", n, LW_N + 1);
      chk("fill_data", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      drop_and_settle();

      // Writeback with two wait cycles per beat.
      wait_n = 2;
      r0 = resp_seen;
      wb = {32'd4, 32'd3, 32'd2, 32'd1};
      push_req(1'b1, 32'h100, wb, 2);
      line_addr = 32'h100;
      wb_line = wb;
      mem_write = 1'b1;
      wait_resp(n);
      drop_and_settle();
      chk("wb_resp_count", resp_seen - r0, 1);

      // Simultaneous requests: write first, read after write drops.
      wait_n = 0;
      r0 = resp_seen;
      wb = {$urandom, $urandom, $urandom, $urandom};
      push_req(1'b1, 32'h2A0, wb, 0);
      push_req(1'b0, 32'h2A0, '0, 0);
      line_addr = 32'h2A0;
      wb_line = wb;
      mem_write = 1'b1;
      mem_read = 1'b1;
      wait_resp(n);
      mem_write = 1'b0;
      // Dropped during RESP: RELEASE, then a single IDLE cycle, then the read burst.
      n = 0;
      for (int k = 0; k < 20 && !mm_rd; k++) begin
         step();
         n++;
      end
      chk("rd_after_wr_gap", n, 3);
      wait_resp(n);
      drop_and_settle();
      chk("both_resp_count", resp_seen - r0, 2);

      // Held request after completion must not restart a burst.
      push_req(1'b0, 32'h3C8, '0, 0);
      line_addr = 32'h3C8;
      mem_read = 1'b1;
      wait_resp(n);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("held_no_strobe", mm_rd | mm_wr | ca_resp, 0);
      end
      mem_read = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("released_idle", mm_rd | mm_wr | ca_resp, 0);
      end

      // Reset during beat 2 of a fill.
      wait_n = 3;
      push_req(1'b0, 32'h40, '0, 3);
      line_addr = 32'h40;
      mem_read = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         found = mm_rd && (mm_addr == 32'h48);
      end
      chk("beat2_reached", found, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_mm_rd", mm_rd, 0);
      chk("rst_mid_fill", fill_line, 0);
      chk("rst_mid_addr", mm_addr, 0);
      exp_beats.delete();
      exp_resp.delete();
      resp_pushed--;
      model_fill = '0;
      mem_read = 1'b0;
      step();
      step();
      // New fill requested in the very cycle reset is released.
      wait_n = 0;
      push_req(1'b0, 32'h7F0, '0, 0);
      line_addr = 32'h7F0;
      mem_read = 1'b1;
      rst = 1'b0;
      wait_resp(n);
      chk("post_rst_latency", n, LW_N + 1);
      drop_and_settle();

      // Randomized traffic.
      for (int t = 0; t < 24; t++) begin
         bit wr;
         int wn;
         wr = 1'($urandom);
         wn = int'($urandom_range(0, 3));
         a  = $urandom;
         wb = {$urandom, $urandom, $urandom, $urandom};
         wait_n = wn;
         push_req(wr, a, wb, wn);
         line_addr = a;
         wb_line = wb;
         mem_write = wr;
         mem_read = !wr;
         wait_resp(n);
         drop_and_settle();
      end

`ifdef BURST_TIMEOUT_EN
      // Watchdog: memory never acks; partial fill is kept.
      begin
         resp_t r;
         no_ack = 1'b1;
         r.fill = model_fill;
         r.err  = 1'b1;
         exp_resp.push_back(r);
         resp_pushed++;
         err_pushed++;
         line_addr = 32'h500;
         mem_read = 1'b1;
         wait_resp(n);
         chk("wdog_latency", n, TMO + 1);
         drop_and_settle();
         no_ack = 1'b0;
      end
`endif

      repeat (3) step();
      chk("total_resp", resp_seen, resp_pushed);
      chk("total_error", err_seen, err_pushed);
      chk("beats_drained", exp_beats.size(), 0);
      chk("resp_drained", exp_resp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
